// File: rtl/dram_result_dumper.sv
// rtl/dram_result_dumper.sv - reads the result matrix from DRAM and streams it out as 8N1 UART bytes
module dram_result_dumper #(
   parameter int         CLKS_PER_BIT = 434,
   parameter logic [7:0] BASE_ADDR    = 8'd0,
   parameter int         RESULT_WORDS = 9,
   parameter int         READ_LATENCY = 2
) (
   input  logic        MAIN_CLOCK,
   input  logic        RESET,
   input  logic        PROCESS_DONE,
   input  logic [15:0] RAM_DATA,
   output logic [7:0]  RAM_ADDRESS,
   output logic        RAM_WREN,
   output logic        DUMP_ACTIVE,
   output logic        DUMP_DONE,
   output logic        UART_TX,
   output logic [7:0]  WORD_INDEX
);
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int LAT_W  = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(READ_LATENCY);
   localparam logic [7:0]        WORD_LAST = 8'((RESULT_WORDS > 0) ? RESULT_WORDS - 1 : 0);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND_HI, S_SEND_LO, S_DONE} state_t;

   state_t            state_q, state_d;
   logic              pd_prev_q;
   logic [7:0]        word_idx_q, word_idx_d;
   logic [15:0]       word_q, word_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [3:0]        bit_q, bit_d;
   logic              tx_q, tx_d;
   logic              start;
   logic [7:0]        tx_byte;
   logic [9:0]        frame;

   assign start   = PROCESS_DONE & ~pd_prev_q;
   assign tx_byte = (state_q == S_SEND_HI) ? word_q[15:8] : word_q[7:0];
   assign frame   = {1'b1, tx_byte, 1'b0};

   // Each SEND state owns one full frame; the bit driven at a clock edge is the one
   // indexed by the counters before that edge, so the start bit appears one cycle after entry.
   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      word_d     = word_q;
      lat_d      = '0;
      baud_d     = '0;
      bit_d      = '0;
      tx_d       = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               word_idx_d = '0;
               state_d    = (RESULT_WORDS == 0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            if (lat_q == LAT_LAST) begin
               word_d  = RAM_DATA;
               state_d = S_SEND_HI;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         S_SEND_HI, S_SEND_LO: begin
            tx_d   = frame[bit_q];
            baud_d = baud_q + 1'b1;
            bit_d  = bit_q;
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               bit_d  = bit_q + 1'b1;
               if (bit_q == 4'd9) begin
                  bit_d = '0;
                  if (state_q == S_SEND_HI) begin
                     state_d = S_SEND_LO;
                  end else if (word_idx_q == WORD_LAST) begin
                     state_d = S_DONE;
                  end else begin
                     state_d    = S_READ;
                     word_idx_d = word_idx_q + 1'b1;
                  end
               end
            end
         end
         S_DONE: begin
            if (!PROCESS_DONE) begin
               state_d    = S_IDLE;
               word_idx_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         pd_prev_q  <= 1'b0;
         word_idx_q <= '0;
         word_q     <= '0;
         lat_q      <= '0;
         baud_q     <= '0;
         bit_q      <= '0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         pd_prev_q  <= PROCESS_DONE;
         word_idx_q <= word_idx_d;
         word_q     <= word_d;
         lat_q      <= lat_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         tx_q       <= tx_d;
      end
   end

   assign RAM_ADDRESS = BASE_ADDR + word_idx_q;
   assign RAM_WREN    = 1'b0;
   assign DUMP_ACTIVE = (state_q == S_READ) || (state_q == S_SEND_HI) || (state_q == S_SEND_LO);
   assign DUMP_DONE   = (state_q == S_DONE);
   assign UART_TX     = tx_q;
   assign WORD_INDEX  = word_idx_q;

endmodule

// File: tb/tb_dram_result_dumper.sv
// tb/tb_dram_result_dumper.sv - directed checks of the DRAM result dumper across four configurations
module tb_dram_result_dumper;
   localparam int CPB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_assert = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        pd_a, pd_b, pd_c, pd_d;
   logic [7:0]  addr_a, addr_b, addr_c, addr_d;
   logic [7:0]  idx_a, idx_b, idx_c, idx_d;
   logic        wren_a, wren_b, wren_c, wren_d;
   logic        act_a, act_b, act_c, act_d;
   logic        done_a, done_b, done_c, done_d;
   logic        tx_a, tx_b, tx_c, tx_d;
   logic [15:0] q_a, q_b, q_c;
   logic [7:0]  ar_a, ar_b, ar_c;
   logic [15:0] mem_a [256];
   logic [15:0] mem_b [256];
   logic [15:0] mem_c [256];

   // registered-address, registered-output DRAM: two cycles of read latency
   always @(posedge clk) begin
      ar_a <= addr_a; q_a <= mem_a[ar_a];
      ar_b <= addr_b; q_b <= mem_b[ar_b];
      ar_c <= addr_c; q_c <= mem_c[ar_c];
   end

   dram_result_dumper #(.CLKS_PER_BIT(CPB), .BASE_ADDR(8'h00), .RESULT_WORDS(1), .READ_LATENCY(2)) u_a (
      .MAIN_CLOCK(clk), .RESET(rst), .PROCESS_DONE(pd_a), .RAM_DATA(q_a), .RAM_ADDRESS(addr_a),
      .RAM_WREN(wren_a), .DUMP_ACTIVE(act_a), .DUMP_DONE(done_a), .UART_TX(tx_a), .WORD_INDEX(idx_a));
   dram_result_dumper #(.CLKS_PER_BIT(CPB), .BASE_ADDR(8'h20), .RESULT_WORDS(9), .READ_LATENCY(2)) u_b (
      .MAIN_CLOCK(clk), .RESET(rst), .PROCESS_DONE(pd_b), .RAM_DATA(q_b), .RAM_ADDRESS(addr_b),
      .RAM_WREN(wren_b), .DUMP_ACTIVE(act_b), .DUMP_DONE(done_b), .UART_TX(tx_b), .WORD_INDEX(idx_b));
   dram_result_dumper #(.CLKS_PER_BIT(CPB), .BASE_ADDR(8'hFE), .RESULT_WORDS(3), .READ_LATENCY(2)) u_c (
      .MAIN_CLOCK(clk), .RESET(rst), .PROCESS_DONE(pd_c), .RAM_DATA(q_c), .RAM_ADDRESS(addr_c),
      .RAM_WREN(wren_c), .DUMP_ACTIVE(act_c), .DUMP_DONE(done_c), .UART_TX(tx_c), .WORD_INDEX(idx_c));
   dram_result_dumper #(.CLKS_PER_BIT(CPB), .BASE_ADDR(8'h00), .RESULT_WORDS(0), .READ_LATENCY(2)) u_d (
      .MAIN_CLOCK(clk), .RESET(rst), .PROCESS_DONE(pd_d), .RAM_DATA(16'hDEAD), .RAM_ADDRESS(addr_d),
      .RAM_WREN(wren_d), .DUMP_ACTIVE(act_d), .DUMP_DONE(done_d), .UART_TX(tx_d), .WORD_INDEX(idx_d));

   logic [1:0] sel;
   logic       tx_sel;
   always_comb begin
      case (sel)
         2'd0:    tx_sel = tx_a;
         2'd1:    tx_sel = tx_b;
         default: tx_sel = tx_c;
      endcase
   end

   logic wren_seen = 1'b0;
   logic d_act_seen = 1'b0;
   logic d_tx_low_seen = 1'b0;
   always @(negedge clk) begin
      if (wren_a | wren_b | wren_c | wren_d) wren_seen = 1'b1;
      if (act_d) d_act_seen = 1'b1;
      if (!tx_d) d_tx_low_seen = 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Decode one 8N1 byte from tx_sel; t is the cycle at which the start bit was first seen.
   task automatic rx_byte(output logic [7:0] b, output int t);
      int n;
      b = '0;
      t = -1;
      n = 0;
      while (tx_sel !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (tx_sel !== 1'b0) begin
         chk("rx_timeout", {31'b0, tx_sel}, 32'd0);
         return;
      end
      t = cyc;
      repeat (CPB / 2) @(negedge clk);
      for (int j = 0; j < 8; j++) begin
         repeat (CPB) @(negedge clk);
         b[j] = tx_sel;
      end
      repeat (CPB) @(negedge clk);
      chk("stop_bit", {31'b0, tx_sel}, 32'd1);
   endtask

   task automatic dump_b();
      logic [7:0] hi, lo;
      int t;
      for (int i = 0; i < 9; i++) begin
         rx_byte(hi, t);
         chk("b_addr", {24'b0, addr_b}, 32'(8'h20 + i));
         rx_byte(lo, t);
         chk("b_hi", {24'b0, hi}, 32'(i));
         chk("b_lo", {24'b0, lo}, 32'(i));
      end
   endtask

   logic [7:0] b0, b1, hi, lo, exp_a;
   int t_edge, t0, t1, n, lows, notdone;

   initial begin
      pd_a = 1'b0; pd_b = 1'b0; pd_c = 1'b0; pd_d = 1'b0;
      sel = 2'd0;
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 16'h0;
         mem_b[i] = 16'hFFFF;
         mem_c[i] = {8'(i), ~8'(i)};
      end
      mem_a[0] = 16'h12A5;
      for (int i = 0; i < 9; i++) mem_b[8'h20 + i] = 16'(16'h0100 * i + i);

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_tx", {31'b0, tx_a}, 32'd1);
      chk("rst_active", {31'b0, act_a}, 32'd0);
      chk("rst_done", {31'b0, done_a}, 32'd0);
      chk("rst_addr_a", {24'b0, addr_a}, 32'h00);
      chk("rst_wren", {31'b0, wren_a}, 32'd0);
      chk("rst_index", {24'b0, idx_a}, 32'd0);
      chk("rst_addr_b", {24'b0, addr_b}, 32'h20);
      chk("rst_addr_c", {24'b0, addr_c}, 32'hFE);
      rst = 1'b0;

      // single word 16'h12A5, pulsed start
      @(negedge clk);
      t_edge = cyc;
      pd_a = 1'b1;
      @(negedge clk);
      chk("a_active_on_read", {31'b0, act_a}, 32'd1);
      chk("a_tx_idle_in_read", {31'b0, tx_a}, 32'd1);
      rx_byte(b0, t0);
      chk("a_first_start_latency", 32'(t0 - t_edge), 32'd5);
      pd_a = 1'b0;
      rx_byte(b1, t1);
      chk("a_byte_hi", {24'b0, b0}, 32'h12);
      chk("a_byte_lo", {24'b0, b1}, 32'hA5);
      chk("a_bytes_contiguous", 32'(t1 - t0), 32'(10 * CPB));
      chk("a_done_during_stop", {31'b0, done_a}, 32'd0);
      @(negedge clk);
      chk("a_done_after_stop", {31'b0, done_a}, 32'd1);
      chk("a_active_after", {31'b0, act_a}, 32'd0);
      @(negedge clk);
      chk("a_done_clears", {31'b0, done_a}, 32'd0);

      // reset during a start bit forces the line high at once
      pd_a = 1'b1;
      n = 0;
      while (tx_a !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("a_start_before_reset", {31'b0, tx_a}, 32'd0);
      rst = 1'b1;
      #1;
      chk("a_tx_high_on_reset", {31'b0, tx_a}, 32'd1);
      chk("a_active_off_on_reset", {31'b0, act_a}, 32'd0);
      @(negedge clk);
      pd_a = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // full 3x3 result, start held high at level
      sel = 2'd1;
      pd_b = 1'b1;
      dump_b();
      @(negedge clk);
      chk("b_active_after", {31'b0, act_b}, 32'd0);
      lows = 0;
      notdone = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx_b !== 1'b1) lows++;
         if (done_b !== 1'b1) notdone++;
      end
      chk("b_level_no_redump", 32'(lows), 32'd0);
      chk("b_level_done_held", 32'(notdone), 32'd0);
      pd_b = 1'b0;
      @(negedge clk);
      chk("b_done_clears", {31'b0, done_b}, 32'd0);
      chk("b_idle_addr", {24'b0, addr_b}, 32'h20);
      pd_b = 1'b1;
      dump_b();
      pd_b = 1'b0;
      repeat (3) @(negedge clk);

      // address wrap FE, FF, 00
      sel = 2'd2;
      pd_c = 1'b1;
      repeat (2) @(negedge clk);
      pd_c = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp_a = 8'(8'hFE + i);
         rx_byte(hi, t0);
         chk("c_addr", {24'b0, addr_c}, {24'b0, exp_a});
         rx_byte(lo, t0);
         chk("c_hi", {24'b0, hi}, {24'b0, exp_a});
         chk("c_lo", {24'b0, lo}, {24'b0, ~exp_a});
      end
      repeat (3) @(negedge clk);
      chk("c_done_clears", {31'b0, done_c}, 32'd0);

      // zero words: straight to DONE with no traffic
      pd_d = 1'b1;
      repeat (2) @(negedge clk);
      chk("d_done_fast", {31'b0, done_d}, 32'd1);
      repeat (20) @(negedge clk);
      chk("d_done_held", {31'b0, done_d}, 32'd1);
      pd_d = 1'b0;
      repeat (2) @(negedge clk);
      chk("d_done_clears", {31'b0, done_d}, 32'd0);
      chk("d_never_active", {31'b0, d_act_seen}, 32'd0);
      chk("d_tx_always_high", {31'b0, d_tx_low_seen}, 32'd0);
      chk("wren_never", {31'b0, wren_seen}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
